// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32IM writeback stage.
//   XLEN       : datapath width
//   NREGS      : architectural register count
//   REG_AW     : register address width
//   gpr_addr_t : register address type
//   wb_src_e   : which result source owns the GPR write port this cycle
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] gpr_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU,
        WB_MDU
    } wb_src_e;

endpackage

// File: rtl/rv_writeback_if.sv
// Bundle of every writeback-stage signal other than clock and reset.
//   ALU channel : alu_valid_i/alu_rd_i/alu_data_i, no backpressure
//   LSU channel : lsu_valid_i/lsu_rd_i/lsu_data_i, lsu_ready_o
//   MDU channel : mdu_valid_i/mdu_rd_i/mdu_data_i, mdu_ready_o
//   Scoreboard  : sb_set_i/sb_set_rd_i mark a long-latency destination pending
//   GPR port    : gpr_wr_en_o/gpr_wr_addr_o/gpr_wr_data_o
//   Hazard      : r1/r2 source addresses in, busy flags out
// Modports: slave = writeback stage, master = surrounding core (or bench).
interface rv_writeback_if;
    import rv_pkg::*;

    logic      alu_valid_i;
    gpr_addr_t alu_rd_i;
    xlen_t     alu_data_i;

    logic      lsu_valid_i;
    gpr_addr_t lsu_rd_i;
    xlen_t     lsu_data_i;
    logic      lsu_ready_o;

    logic      mdu_valid_i;
    gpr_addr_t mdu_rd_i;
    xlen_t     mdu_data_i;
    logic      mdu_ready_o;

    logic      sb_set_i;
    gpr_addr_t sb_set_rd_i;

    logic      gpr_wr_en_o;
    gpr_addr_t gpr_wr_addr_o;
    xlen_t     gpr_wr_data_o;

    gpr_addr_t r1_addr_i;
    gpr_addr_t r2_addr_i;
    logic      r1_busy_o;
    logic      r2_busy_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output lsu_ready_o,
        input  mdu_valid_i, mdu_rd_i, mdu_data_i,
        output mdu_ready_o,
        input  sb_set_i, sb_set_rd_i,
        output gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o,
        input  r1_addr_i, r2_addr_i,
        output r1_busy_o, r2_busy_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  lsu_ready_o,
        output mdu_valid_i, mdu_rd_i, mdu_data_i,
        input  mdu_ready_o,
        output sb_set_i, sb_set_rd_i,
        input  gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o,
        output r1_addr_i, r2_addr_i,
        input  r1_busy_o, r2_busy_o
    );

endinterface

// File: rtl/rv_wb_scoreboard.sv
// Pending-write scoreboard: one bit per GPR, set when a long-latency
// instruction issues, cleared when its result is accepted by writeback.
//   clk_i, arstn_i   : clock, asynchronous active-low reset
//   i_set, i_set_rd  : mark a destination pending (rd 0 ignored)
//   i_clr, i_clr_rd  : accepted LSU/MDU transfer, release its destination
//   i_r1_addr/i_r2_addr -> o_r1_pending/o_r2_pending : lookups
module rv_wb_scoreboard
    import rv_pkg::*;
(
    input  logic      clk_i,
    input  logic      arstn_i,
    input  logic      i_set,
    input  gpr_addr_t i_set_rd,
    input  logic      i_clr,
    input  gpr_addr_t i_clr_rd,
    input  gpr_addr_t i_r1_addr,
    input  gpr_addr_t i_r2_addr,
    output logic      o_r1_pending,
    output logic      o_r2_pending
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_d;

    always_comb begin
        w_pending_d = r_pending;
        if (i_clr) begin
            w_pending_d[i_clr_rd] = 1'b0;
        end
        // Applied after the clear so a same-edge set on the same rd survives.
        if (i_set && (i_set_rd != '0)) begin
            w_pending_d[i_set_rd] = 1'b1;
        end
        w_pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_d;
        end
    end

    assign o_r1_pending = r_pending[i_r1_addr];
    assign o_r2_pending = r_pending[i_r2_addr];

endmodule

// File: rtl/rv_writeback.sv
// Writeback stage: arbitrates ALU, LSU and MDU results onto the single GPR
// write port through one output register, and reports operand hazards.
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   wb (slave)     : result channels, scoreboard set, GPR port, busy lookups
// ALU always wins; LSU and MDU alternate when they contend.
module rv_writeback
    import rv_pkg::*;
(
    input  logic          clk_i,
    input  logic          arstn_i,
    rv_writeback_if.slave wb
);

    // 1 = MDU won the last decided contest, so LSU is preferred next.
    logic      r_last_mdu;
    logic      r_wr_en;
    gpr_addr_t r_wr_addr;
    xlen_t     r_wr_data;

    logic      w_lsu_pref;
    logic      w_lsu_ready;
    logic      w_mdu_ready;
    logic      w_contest;
    wb_src_e   w_src;
    gpr_addr_t w_rd;
    xlen_t     w_data;
    logic      w_r1_pending;
    logic      w_r2_pending;

    assign w_lsu_pref  = r_last_mdu;
    assign w_lsu_ready = wb.lsu_valid_i & ~wb.alu_valid_i & (w_lsu_pref | ~wb.mdu_valid_i);
    assign w_mdu_ready = wb.mdu_valid_i & ~wb.alu_valid_i & (~w_lsu_pref | ~wb.lsu_valid_i);
    assign w_contest   = wb.lsu_valid_i & wb.mdu_valid_i & ~wb.alu_valid_i;

    always_comb begin
        w_src = WB_NONE;
        if (wb.alu_valid_i) begin
            w_src = WB_ALU;
        end else if (w_lsu_ready) begin
            w_src = WB_LSU;
        end else if (w_mdu_ready) begin
            w_src = WB_MDU;
        end
    end

    always_comb begin
        w_rd   = '0;
        w_data = '0;
        unique case (w_src)
            WB_ALU: begin
                w_rd   = wb.alu_rd_i;
                w_data = wb.alu_data_i;
            end
            WB_LSU: begin
                w_rd   = wb.lsu_rd_i;
                w_data = wb.lsu_data_i;
            end
            WB_MDU: begin
                w_rd   = wb.mdu_rd_i;
                w_data = wb.mdu_data_i;
            end
            default: begin
                w_rd   = '0;
                w_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_last_mdu <= 1'b1;
        end else if (w_contest) begin
            r_last_mdu <= w_mdu_ready;
        end
    end

    // Address/data only load on a transfer; the enable alone marks a write.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= (w_src != WB_NONE) && (w_rd != '0);
            if (w_src != WB_NONE) begin
                r_wr_addr <= w_rd;
                r_wr_data <= w_data;
            end
        end
    end

    rv_wb_scoreboard u_scoreboard (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .i_set        (wb.sb_set_i),
        .i_set_rd     (wb.sb_set_rd_i),
        .i_clr        (w_lsu_ready | w_mdu_ready),
        .i_clr_rd     (w_rd),
        .i_r1_addr    (wb.r1_addr_i),
        .i_r2_addr    (wb.r2_addr_i),
        .o_r1_pending (w_r1_pending),
        .o_r2_pending (w_r2_pending)
    );

    assign wb.lsu_ready_o   = w_lsu_ready;
    assign wb.mdu_ready_o   = w_mdu_ready;
    assign wb.gpr_wr_en_o   = r_wr_en;
    assign wb.gpr_wr_addr_o = r_wr_addr;
    assign wb.gpr_wr_data_o = r_wr_data;

    // In-flight term covers the cycle between pending clear and GPR write.
    // r_wr_en is never set for rd 0, so address 0 is never busy.
    assign wb.r1_busy_o = w_r1_pending | (r_wr_en & (r_wr_addr == wb.r1_addr_i));
    assign wb.r2_busy_o = w_r2_pending | (r_wr_en & (r_wr_addr == wb.r2_addr_i));

endmodule

// File: tb/tb_rv_writeback.sv
// Directed self-checking bench for rv_writeback.
module tb_rv_writeback;
    import rv_pkg::*;

    logic clk;
    logic arstn;
    int   n_tests;
    int   n_fail;

    rv_writeback_if wb_if ();

    rv_writeback u_dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .wb      (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_if.alu_valid_i = 1'b0;
        wb_if.alu_rd_i    = '0;
        wb_if.alu_data_i  = '0;
        wb_if.lsu_valid_i = 1'b0;
        wb_if.lsu_rd_i    = '0;
        wb_if.lsu_data_i  = '0;
        wb_if.mdu_valid_i = 1'b0;
        wb_if.mdu_rd_i    = '0;
        wb_if.mdu_data_i  = '0;
        wb_if.sb_set_i    = 1'b0;
        wb_if.sb_set_rd_i = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        wb_if.r1_addr_i = 5'd5;
        wb_if.r2_addr_i = 5'd0;
        arstn = 1'b0;

        // Reset state; ready stays combinational during reset.
        #12;
        check("rst_wr_en",   32'(wb_if.gpr_wr_en_o), 32'd0);
        check("rst_wr_addr", 32'(wb_if.gpr_wr_addr_o), 32'd0);
        check("rst_wr_data", wb_if.gpr_wr_data_o, 32'd0);
        check("rst_r1_busy", 32'(wb_if.r1_busy_o), 32'd0);
        wb_if.lsu_valid_i = 1'b1;
        #1;
        check("rst_lsu_ready_comb", 32'(wb_if.lsu_ready_o), 32'd1);
        wb_if.lsu_valid_i = 1'b0;
        step();
        arstn = 1'b1;
        step();

        // ALU wins, LSU/MDU see no ready; no contest so preference unchanged.
        wb_if.alu_valid_i = 1'b1;
        wb_if.alu_rd_i    = 5'd5;
        wb_if.alu_data_i  = 32'hDEADBEEF;
        wb_if.lsu_valid_i = 1'b1;
        wb_if.lsu_rd_i    = 5'd3;
        wb_if.mdu_valid_i = 1'b1;
        wb_if.mdu_rd_i    = 5'd4;
        #1;
        check("alu_lsu_ready", 32'(wb_if.lsu_ready_o), 32'd0);
        check("alu_mdu_ready", 32'(wb_if.mdu_ready_o), 32'd0);
        step();
        idle_inputs();
        check("alu_wr_en",   32'(wb_if.gpr_wr_en_o), 32'd1);
        check("alu_wr_addr", 32'(wb_if.gpr_wr_addr_o), 32'd5);
        check("alu_wr_data", wb_if.gpr_wr_data_o, 32'hDEADBEEF);
        check("alu_inflight_busy", 32'(wb_if.r1_busy_o), 32'd1);
        check("alu_ready_after", 32'(wb_if.lsu_ready_o), 32'd0);
        step();
        check("alu_wr_en_drop", 32'(wb_if.gpr_wr_en_o), 32'd0);
        check("alu_busy_drop",  32'(wb_if.r1_busy_o), 32'd0);

        // LSU/MDU contention alternates starting with LSU.
        for (int i = 0; i < 4; i++) begin
            wb_if.lsu_valid_i = 1'b1;
            wb_if.lsu_rd_i    = 5'd10;
            wb_if.lsu_data_i  = 32'hA000_0000 + 32'(i);
            wb_if.mdu_valid_i = 1'b1;
            wb_if.mdu_rd_i    = 5'd11;
            wb_if.mdu_data_i  = 32'hB000_0000 + 32'(i);
            #1;
            check("rr_lsu_ready", 32'(wb_if.lsu_ready_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_mdu_ready", 32'(wb_if.mdu_ready_o), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check("rr_wr_en",   32'(wb_if.gpr_wr_en_o), 32'd1);
            check("rr_wr_addr", 32'(wb_if.gpr_wr_addr_o), (i % 2 == 0) ? 32'd10 : 32'd11);
            check("rr_wr_data", wb_if.gpr_wr_data_o,
                  (i % 2 == 0) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i));
        end
        idle_inputs();
        step();

        // ALU blocks a waiting LSU for three cycles.
        wb_if.lsu_valid_i = 1'b1;
        wb_if.lsu_rd_i    = 5'd12;
        wb_if.lsu_data_i  = 32'h0000_C0DE;
        for (int i = 0; i < 3; i++) begin
            wb_if.alu_valid_i = 1'b1;
            wb_if.alu_rd_i    = 5'(i + 1);
            wb_if.alu_data_i  = 32'(i + 100);
            #1;
            check("blk_lsu_ready", 32'(wb_if.lsu_ready_o), 32'd0);
            step();
            check("blk_alu_addr", 32'(wb_if.gpr_wr_addr_o), 32'(i + 1));
        end
        wb_if.alu_valid_i = 1'b0;
        #1;
        check("blk_lsu_ready_free", 32'(wb_if.lsu_ready_o), 32'd1);
        step();
        wb_if.lsu_valid_i = 1'b0;
        check("blk_lsu_addr", 32'(wb_if.gpr_wr_addr_o), 32'd12);
        check("blk_lsu_data", wb_if.gpr_wr_data_o, 32'h0000_C0DE);

        // Scoreboard: set rd 7, hold busy until the cycle after its GPR write.
        wb_if.r1_addr_i   = 5'd7;
        wb_if.sb_set_i    = 1'b1;
        wb_if.sb_set_rd_i = 5'd7;
        #1;
        check("sb7_before_set", 32'(wb_if.r1_busy_o), 32'd0);
        step();
        wb_if.sb_set_i = 1'b0;
        check("sb7_set", 32'(wb_if.r1_busy_o), 32'd1);
        step();
        check("sb7_hold", 32'(wb_if.r1_busy_o), 32'd1);
        wb_if.mdu_valid_i = 1'b1;
        wb_if.mdu_rd_i    = 5'd7;
        wb_if.mdu_data_i  = 32'h0000_0077;
        #1;
        check("sb7_mdu_ready", 32'(wb_if.mdu_ready_o), 32'd1);
        step();
        wb_if.mdu_valid_i = 1'b0;
        check("sb7_inflight", 32'(wb_if.r1_busy_o), 32'd1);
        check("sb7_wr_addr", 32'(wb_if.gpr_wr_addr_o), 32'd7);
        step();
        check("sb7_cleared", 32'(wb_if.r1_busy_o), 32'd0);

        // rd 0: set ignored, transfer completes without a write.
        wb_if.r1_addr_i   = 5'd0;
        wb_if.sb_set_i    = 1'b1;
        wb_if.sb_set_rd_i = 5'd0;
        wb_if.mdu_valid_i = 1'b1;
        wb_if.mdu_rd_i    = 5'd0;
        #1;
        check("rd0_mdu_ready", 32'(wb_if.mdu_ready_o), 32'd1);
        step();
        idle_inputs();
        check("rd0_no_write", 32'(wb_if.gpr_wr_en_o), 32'd0);
        check("rd0_busy1", 32'(wb_if.r1_busy_o), 32'd0);
        check("rd0_busy2", 32'(wb_if.r2_busy_o), 32'd0);

        // Same-edge set and clear of rd 9: set wins.
        wb_if.r1_addr_i   = 5'd9;
        wb_if.sb_set_i    = 1'b1;
        wb_if.sb_set_rd_i = 5'd9;
        step();
        wb_if.lsu_valid_i = 1'b1;
        wb_if.lsu_rd_i    = 5'd9;
        wb_if.lsu_data_i  = 32'h0000_0099;
        #1;
        check("sb9_lsu_ready", 32'(wb_if.lsu_ready_o), 32'd1);
        step();
        idle_inputs();
        step();
        check("sb9_wr_en_idle", 32'(wb_if.gpr_wr_en_o), 32'd0);
        check("sb9_still_pending", 32'(wb_if.r1_busy_o), 32'd1);

        // Reset while an LSU write sits in the output register.
        wb_if.r2_addr_i   = 5'd13;
        wb_if.lsu_valid_i = 1'b1;
        wb_if.lsu_rd_i    = 5'd13;
        wb_if.lsu_data_i  = 32'h0000_00D1;
        step();
        wb_if.lsu_valid_i = 1'b0;
        check("rst_mid_wr_en_before", 32'(wb_if.gpr_wr_en_o), 32'd1);
        check("rst_mid_busy2_before", 32'(wb_if.r2_busy_o), 32'd1);
        arstn = 1'b0;
        #1;
        check("rst_mid_wr_en",   32'(wb_if.gpr_wr_en_o), 32'd0);
        check("rst_mid_wr_addr", 32'(wb_if.gpr_wr_addr_o), 32'd0);
        check("rst_mid_busy1",   32'(wb_if.r1_busy_o), 32'd0);
        check("rst_mid_busy2",   32'(wb_if.r2_busy_o), 32'd0);
        step();
        arstn = 1'b1;
        step();
        check("rst_post_busy1", 32'(wb_if.r1_busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
